// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - shared encodings for the unified memory port scheduler
package mem_sched_pkg;

    // Scheduler FSM: idle, or one transaction outstanding for fetch or data
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_F = 2'b01,
        BUSY_D = 2'b10
    } state_t;

    // Owner of the most recent / current grant
    typedef enum logic {
        GNT_F = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    // Transaction sizes as seen on d_size / mem_size
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/mem_rr_arb2.sv
// rtl/mem_rr_arb2.sv - two-way round-robin arbiter between fetch and data requesters
module mem_rr_arb2
    import mem_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_f,
    input  logic req_d,
    input  logic update,
    output logic gnt_valid,
    output gnt_t gnt_owner
);

    gnt_t last_grant;

    // Pick the owner: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        gnt_valid = req_f | req_d;
        gnt_owner = GNT_F;
        if (req_f && req_d) begin
            gnt_owner = (last_grant == GNT_F) ? GNT_D : GNT_F;
        end else if (req_d) begin
            gnt_owner = GNT_D;
        end
    end

    // Remember the last owner; reset to fetch so data wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GNT_F;
        end else if (update && gnt_valid) begin
            last_grant <= gnt_owner;
        end
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// rtl/mem_port_scheduler.sv - req/ack sequencer sharing one memory port between fetch and load/store
module mem_port_scheduler
    import mem_sched_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              cpu_stall,
    output logic              err
);

    localparam int               CNT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t            state_q;
    state_t            state_nx;
    logic [CNT_W-1:0]  wait_q;
    logic [CNT_W-1:0]  wait_nx;
    logic              req_nx;
    logic              we_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_nx;
    logic [1:0]        size_nx;
    logic              if_valid_nx;
    logic              d_done_nx;
    logic              err_nx;
    logic [DATA_W-1:0] if_rdata_nx;
    logic [DATA_W-1:0] d_rdata_nx;

    logic              pend_f;
    logic              pend_d;
    logic              gnt_valid;
    gnt_t              gnt_owner;

    // A requester still holding its request on its own done cycle is not a new request
    assign pend_f    = if_req & ~if_valid;
    assign pend_d    = (d_rd | d_wr) & ~d_done;
    assign cpu_stall = pend_f | pend_d;

    mem_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_f     (pend_f),
        .req_d     (pend_d),
        .update    (state_q == IDLE),
        .gnt_valid (gnt_valid),
        .gnt_owner (gnt_owner)
    );

    // Next-state and next-output logic: grant in IDLE, complete or time out in BUSY
    always_comb begin
        state_nx    = state_q;
        wait_nx     = wait_q;
        req_nx      = mem_req;
        we_nx       = mem_we;
        addr_nx     = mem_addr;
        wdata_nx    = mem_wdata;
        size_nx     = mem_size;
        if_valid_nx = 1'b0;
        d_done_nx   = 1'b0;
        err_nx      = 1'b0;
        if_rdata_nx = if_rdata;
        d_rdata_nx  = d_rdata;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    req_nx  = 1'b1;
                    wait_nx = '0;
                    if (gnt_owner == GNT_D) begin
                        // Store wins when both strobes are (illegally) high
                        state_nx = BUSY_D;
                        we_nx    = d_wr;
                        addr_nx  = d_addr;
                        wdata_nx = d_wdata;
                        size_nx  = d_size;
                    end else begin
                        state_nx = BUSY_F;
                        we_nx    = 1'b0;
                        addr_nx  = if_addr;
                        wdata_nx = '0;
                        size_nx  = SZ_W;
                    end
                end
            end
            BUSY_F, BUSY_D: begin
                // An ack arriving on the final wait cycle still completes normally
                if (mem_ack || (wait_q == WAIT_LAST)) begin
                    state_nx = IDLE;
                    req_nx   = 1'b0;
                    we_nx    = 1'b0;
                    err_nx   = ~mem_ack;
                    if (state_q == BUSY_F) begin
                        if_valid_nx = 1'b1;
                        if_rdata_nx = mem_ack ? mem_rdata : '0;
                    end else begin
                        d_done_nx = 1'b1;
                        if (!mem_we) begin
                            d_rdata_nx = mem_ack ? mem_rdata : '0;
                        end
                    end
                end else begin
                    wait_nx = wait_q + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, memory-side fields and requester-side results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_size  <= SZ_W;
            if_valid  <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state_q   <= state_nx;
            wait_q    <= wait_nx;
            mem_req   <= req_nx;
            mem_we    <= we_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            mem_size  <= size_nx;
            if_valid  <= if_valid_nx;
            d_done    <= d_done_nx;
            err       <= err_nx;
            if_rdata  <= if_rdata_nx;
            d_rdata   <= d_rdata_nx;
        end
    end

    // Load and store strobes together is a core bug
    illegal_rd_wr: assert property (@(posedge clk) disable iff (rst) !(d_rd && d_wr));

endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb/tb_mem_port_scheduler.sv - vector, directed and randomized checks of mem_port_scheduler
module tb_mem_port_scheduler;
    import mem_sched_pkg::*;

    localparam int MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst, if_req, d_rd, d_wr, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [1:0]  d_size;
    logic        mem_req, mem_we, if_valid, d_done, cpu_stall, err;
    logic [31:0] mem_addr, mem_wdata, if_rdata, d_rdata;
    logic [1:0]  mem_size;

    always #5 clk = ~clk;

    mem_port_scheduler #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .if_valid(if_valid), .if_rdata(if_rdata), .d_done(d_done), .d_rdata(d_rdata),
        .cpu_stall(cpu_stall), .err(err)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Transaction-level reference: what the registered outputs must be after the next edge
    logic        e_req, e_we, e_ifv, e_dd, e_err;
    logic [31:0] e_addr, e_wdata, e_ifr, e_drd;
    logic [1:0]  e_size;
    bit          m_busy, m_own_d, m_last_d;
    int          m_wait;

    task automatic model_step();
        bit pf, pd, take_d;
        if (rst) begin
            e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_size = SZ_W;
            e_ifv = 0; e_dd = 0; e_err = 0; e_ifr = 0; e_drd = 0;
            m_busy = 0; m_own_d = 0; m_last_d = 0; m_wait = 0;
            return;
        end
        pf = if_req && !e_ifv;
        pd = (d_rd || d_wr) && !e_dd;
        e_ifv = 0; e_dd = 0; e_err = 0;
        if (!m_busy) begin
            if (pf || pd) begin
                take_d   = pd && !(pf && m_last_d);
                m_last_d = take_d;
                m_own_d  = take_d;
                m_busy   = 1;
                m_wait   = 0;
                e_req    = 1;
                if (take_d) begin
                    e_we = d_wr; e_addr = d_addr; e_wdata = d_wdata; e_size = d_size;
                end else begin
                    e_we = 0; e_addr = if_addr; e_size = SZ_W;
                end
            end
        end else if (mem_ack) begin
            m_busy = 0; e_req = 0;
            if (m_own_d) begin e_dd = 1; if (!e_we) e_drd = mem_rdata; end
            else begin e_ifv = 1; e_ifr = mem_rdata; end
            e_we = 0;
        end else begin
            m_wait++;
            if (m_wait == MAX_WAIT) begin
                m_busy = 0; e_req = 0; e_err = 1;
                if (m_own_d) begin e_dd = 1; if (!e_we) e_drd = 0; end
                else begin e_ifv = 1; e_ifr = 0; end
                e_we = 0;
            end
        end
    endtask

    // Advance one cycle: inputs are driven just after a falling edge, outputs sampled 1ns later
    task automatic next();
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  stim;    // {rst, if_req, d_rd, mem_ack}
        logic [31:0] rdata;
        logic [3:0]  xo;      // {mem_req, if_valid, d_done, cpu_stall}
        logic [31:0] x_addr;
        logic [31:0] x_ifr;
        logic [31:0] x_drd;
    } vec_t;

    vec_t vt [14];
    int   ack_pct;

    initial begin
        // Fetch after reset, then reset and a fetch/load tie that must alternate data-first
        vt[0]  = '{4'b0100, 32'h0,  4'b0001, 32'h0,  32'h0,  32'h0};
        vt[1]  = '{4'b0101, 32'h13, 4'b1001, 32'h40, 32'h0,  32'h0};
        vt[2]  = '{4'b0100, 32'h0,  4'b0100, 32'h0,  32'h13, 32'h0};
        vt[3]  = '{4'b0000, 32'h0,  4'b0000, 32'h0,  32'h13, 32'h0};
        vt[4]  = '{4'b1000, 32'h0,  4'b0000, 32'h0,  32'h13, 32'h0};
        vt[5]  = '{4'b0110, 32'h0,  4'b0001, 32'h0,  32'h0,  32'h0};
        vt[6]  = '{4'b0111, 32'hA5, 4'b1001, 32'h80, 32'h0,  32'h0};
        vt[7]  = '{4'b0110, 32'h0,  4'b0011, 32'h0,  32'h0,  32'hA5};
        vt[8]  = '{4'b0111, 32'h77, 4'b1001, 32'h40, 32'h0,  32'hA5};
        vt[9]  = '{4'b0110, 32'h0,  4'b0101, 32'h0,  32'h77, 32'hA5};
        vt[10] = '{4'b0111, 32'h55, 4'b1001, 32'h80, 32'h77, 32'hA5};
        vt[11] = '{4'b0110, 32'h0,  4'b0011, 32'h0,  32'h77, 32'h55};
        vt[12] = '{4'b0111, 32'h66, 4'b1001, 32'h40, 32'h77, 32'h55};
        vt[13] = '{4'b0000, 32'h0,  4'b0100, 32'h0,  32'h66, 32'h55};

        rst = 1; if_req = 0; d_rd = 0; d_wr = 0; mem_ack = 0;
        if_addr = 32'h40; d_addr = 32'h80; d_wdata = 0; d_size = SZ_W; mem_rdata = 0;
        @(negedge clk);
        #1; next();
        #1; next();

        // Reset state
        rst = 0; #1;
        chk1("rst mem_req", mem_req, 1'b0);
        chk1("rst mem_we", mem_we, 1'b0);
        chk32("rst mem_size", 32'(mem_size), 32'(SZ_W));
        chk32("rst mem_addr", mem_addr, 32'h0);
        chk32("rst mem_wdata", mem_wdata, 32'h0);
        chk32("rst if_rdata", if_rdata, 32'h0);
        chk32("rst d_rdata", d_rdata, 32'h0);
        chk1("rst if_valid", if_valid, 1'b0);
        chk1("rst d_done", d_done, 1'b0);
        chk1("rst err", err, 1'b0);
        chk1("rst cpu_stall", cpu_stall, 1'b0);
        next();

        for (int i = 0; i < 14; i++) begin
            {rst, if_req, d_rd, mem_ack} = vt[i].stim;
            mem_rdata = vt[i].rdata;
            #1;
            chk1($sformatf("vec%0d mem_req", i), mem_req, vt[i].xo[3]);
            if (vt[i].xo[3]) begin
                chk32($sformatf("vec%0d mem_addr", i), mem_addr, vt[i].x_addr);
                chk1($sformatf("vec%0d mem_we", i), mem_we, 1'b0);
            end
            chk1($sformatf("vec%0d if_valid", i), if_valid, vt[i].xo[2]);
            chk1($sformatf("vec%0d d_done", i), d_done, vt[i].xo[1]);
            chk1($sformatf("vec%0d cpu_stall", i), cpu_stall, vt[i].xo[0]);
            chk32($sformatf("vec%0d if_rdata", i), if_rdata, vt[i].x_ifr);
            chk32($sformatf("vec%0d d_rdata", i), d_rdata, vt[i].x_drd);
            next();
        end

        // Byte store held stable through 5 wait cycles, acked on the 6th
        d_wr = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_size = SZ_B; mem_ack = 0;
        #1; next();
        for (int i = 0; i < 6; i++) begin
            mem_ack = (i == 5); mem_rdata = 32'hFFFF_FFFF;
            #1;
            chk1($sformatf("st%0d mem_req", i), mem_req, 1'b1);
            chk1($sformatf("st%0d mem_we", i), mem_we, 1'b1);
            chk32($sformatf("st%0d mem_addr", i), mem_addr, 32'h100);
            chk32($sformatf("st%0d mem_wdata", i), mem_wdata, 32'hDEADBEEF);
            chk32($sformatf("st%0d mem_size", i), 32'(mem_size), 32'(SZ_B));
            next();
        end
        mem_ack = 0; #1;
        chk1("st done", d_done, 1'b1);
        chk1("st req_drop", mem_req, 1'b0);
        chk32("st d_rdata_kept", d_rdata, 32'h55);
        chk1("st stall", cpu_stall, 1'b0);
        next();
        d_wr = 0;

        // Load never acked: abort after MAX_WAIT cycles
        d_rd = 1; d_addr = 32'h200; d_size = SZ_W;
        #1; next();
        for (int i = 0; i < MAX_WAIT; i++) begin
            #1;
            chk1($sformatf("to%0d mem_req", i), mem_req, 1'b1);
            chk1($sformatf("to%0d err", i), err, 1'b0);
            next();
        end
        #1;
        chk1("to mem_req_drop", mem_req, 1'b0);
        chk1("to err", err, 1'b1);
        chk1("to d_done", d_done, 1'b1);
        chk32("to d_rdata", d_rdata, 32'h0);
        next();
        d_rd = 0; #1;
        chk1("to err_pulse", err, 1'b0);
        chk1("to done_pulse", d_done, 1'b0);
        next();

        // Ack on the final allowed cycle completes normally
        d_rd = 1; d_addr = 32'h300;
        #1; next();
        for (int i = 0; i < MAX_WAIT - 1; i++) begin #1; next(); end
        mem_ack = 1; mem_rdata = 32'h1234; #1;
        chk1("edge mem_req", mem_req, 1'b1);
        next();
        mem_ack = 0; #1;
        chk1("edge err", err, 1'b0);
        chk1("edge d_done", d_done, 1'b1);
        chk32("edge d_rdata", d_rdata, 32'h1234);
        next();
        d_rd = 0;
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1; mem_rdata = 32'hBAD0_0000 + 32'(i); #1;
            chk1($sformatf("stray%0d mem_req", i), mem_req, 1'b0);
            chk1($sformatf("stray%0d d_done", i), d_done, 1'b0);
            chk32($sformatf("stray%0d d_rdata", i), d_rdata, 32'h1234);
            chk32($sformatf("stray%0d if_rdata", i), if_rdata, 32'h66);
            next();
        end
        mem_ack = 0;

        // Reset during a data transaction; last grant was data, reset must restore data-first
        d_rd = 1; d_addr = 32'h400;
        #1; next();
        rst = 1; #1;
        chk1("rstb mem_req", mem_req, 1'b1);
        next();
        rst = 0; if_req = 1; if_addr = 32'h40; #1;
        chk1("rstb req_drop", mem_req, 1'b0);
        chk1("rstb no_done", d_done, 1'b0);
        next();
        mem_ack = 1; mem_rdata = 32'h99; #1;
        chk1("rstb regrant", mem_req, 1'b1);
        chk32("rstb data_first", mem_addr, 32'h400);
        next();
        mem_ack = 0; if_req = 0; d_rd = 0; #1;
        chk1("rstb d_done", d_done, 1'b1);
        next();

        // Randomized protocol-following requesters and memory against the reference
        rst = 1; #1; next(); #1; next();
        rst = 0;
        for (int c = 0; c < 3000; c++) begin
            case ((c / 200) % 4)
                0: ack_pct = 70;
                1: ack_pct = 20;
                2: ack_pct = 6;
                default: ack_pct = 0;
            endcase
            rst = ($urandom_range(299, 0) == 0);
            if (if_req && if_valid) begin
                if ($urandom_range(1, 0) == 1) if_addr = $urandom & 32'hFFFF_FFFC;
                else if_req = 0;
            end else if (!if_req && $urandom_range(2, 0) == 0) begin
                if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if ((d_rd || d_wr) && d_done) begin
                d_rd = 0; d_wr = 0;
            end else if (!(d_rd || d_wr) && $urandom_range(2, 0) == 0) begin
                d_wr = ($urandom_range(1, 0) == 1); d_rd = !d_wr;
                d_addr = $urandom; d_wdata = $urandom; d_size = 2'($urandom_range(2, 0));
            end
            mem_ack = ($urandom_range(99, 0) < ack_pct);
            mem_rdata = $urandom;
            #1;
            chk1("rnd mem_req", mem_req, e_req);
            if (e_req) begin
                chk1("rnd mem_we", mem_we, e_we);
                chk32("rnd mem_addr", mem_addr, e_addr);
                chk32("rnd mem_size", 32'(mem_size), 32'(e_size));
                if (e_we) chk32("rnd mem_wdata", mem_wdata, e_wdata);
            end
            chk1("rnd if_valid", if_valid, e_ifv);
            chk32("rnd if_rdata", if_rdata, e_ifr);
            chk1("rnd d_done", d_done, e_dd);
            chk32("rnd d_rdata", d_rdata, e_drd);
            chk1("rnd err", err, e_err);
            chk1("rnd cpu_stall", cpu_stall, (if_req & ~e_ifv) | ((d_rd | d_wr) & ~e_dd));
            next();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
